// File: rtl/prefetch_buffer.sv
// ============================================================================
//  Module      : prefetch_buffer
//  Description : Instruction prefetch FIFO that fetches aligned 32-bit words
//                and presents 16/32-bit instructions at halfword-aligned PCs.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module prefetch_buffer #(
   parameter logic [31:0] PC_RESET        = 32'h0000_0000,
   parameter int          DEPTH           = 3,
   parameter int          NUM_OUTSTANDING = 2
) (
   input  logic        clk,
   input  logic        rstn,
   output logic        instr_req_o,
   input  logic        instr_gnt_i,
   output logic [31:0] instr_addr_o,
   input  logic        instr_rvalid_i,
   input  logic [31:0] instr_rdata_i,
   input  logic        instr_err_i,
   input  logic        branch_i,
   input  logic [31:0] branch_addr_i,
   output logic        out_valid_o,
   input  logic        out_ready_i,
   output logic [31:0] out_instr_o,
   output logic [31:0] out_pc_o,
   output logic        out_compressed_o,
   output logic        out_err_o,
   output logic        busy_o
);

   localparam int          CNT_W   = $clog2(DEPTH + 1);
   localparam logic [31:0] PC_INIT = {PC_RESET[31:2], 2'b00};

   logic [31:0]      word_q [DEPTH];
   logic [31:0]      word_d [DEPTH];
   logic [DEPTH-1:0] err_q, err_d;
   logic [CNT_W-1:0] occ_q, occ_d;
   logic [CNT_W-1:0] outst_q, outst_d;
   logic [CNT_W-1:0] disc_q, disc_d;
   logic [31:0]      faddr_q, faddr_d;
   logic [31:0]      pc_q, pc_d;

   logic [CNT_W:0]   used;
   logic             fire_req, resp, drop, push, pop, fire_out;
   logic             has0, has1, comp, need1, err_w;
   logic [15:0]      half_lo;
   logic [CNT_W-1:0] occ_pop;
   logic             unused_bit0;

   assign unused_bit0 = branch_addr_i[0];

   // Space is reserved for every in-flight request that will not be dropped.
   assign used        = {1'b0, occ_q} + {1'b0, outst_q} - {1'b0, disc_q};
   assign instr_req_o = rstn && (outst_q < CNT_W'(NUM_OUTSTANDING))
                             && (used < (CNT_W + 1)'(DEPTH));
   assign instr_addr_o = faddr_q;
   assign busy_o       = (outst_q != '0);

   assign fire_req = instr_req_o & instr_gnt_i;
   assign resp     = instr_rvalid_i & (outst_q != '0);
   assign drop     = resp & (disc_q != '0);
   assign push     = resp & (disc_q == '0) & ~branch_i;

   // Instruction extraction from the head of the FIFO.
   assign has0    = (occ_q != '0);
   assign has1    = (occ_q >= CNT_W'(2));
   assign half_lo = pc_q[1] ? word_q[0][31:16] : word_q[0][15:0];
   assign comp    = (half_lo[1:0] != 2'b11);
   assign need1   = pc_q[1] & ~comp;
   assign err_w   = err_q[0] | (need1 & has1 & err_q[1]);

   always_comb begin
      out_valid_o = 1'b0;
      out_instr_o = 32'h0;
      if (err_q[0]) begin
         out_valid_o = has0;
      end else if (need1) begin
         out_valid_o = has1;
      end else begin
         out_valid_o = has0;
      end
      if (err_w) begin
         out_instr_o = 32'h0;
      end else if (comp) begin
         out_instr_o = {16'h0, half_lo};
      end else if (pc_q[1]) begin
         out_instr_o = {word_q[1][15:0], half_lo};
      end else begin
         out_instr_o = word_q[0];
      end
   end

   assign out_err_o        = out_valid_o & err_w;
   assign out_compressed_o = comp;
   assign out_pc_o         = pc_q;

   assign fire_out = out_valid_o & out_ready_i & ~branch_i;
   // Entry0 is consumed once the instruction reaches the word boundary.
   assign pop      = fire_out & (pc_q[1] | ~comp);

   always_comb begin
      word_d  = word_q;
      err_d   = err_q;
      occ_pop = occ_q - CNT_W'(pop);
      occ_d   = occ_pop;
      if (pop) begin
         for (int i = 0; i < DEPTH - 1; i++) begin
            word_d[i] = word_q[i+1];
            err_d[i]  = err_q[i+1];
         end
      end
      if (push) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (occ_pop == CNT_W'(i)) begin
               word_d[i] = instr_rdata_i;
               err_d[i]  = instr_err_i;
            end
         end
         occ_d = occ_pop + CNT_W'(1);
      end
      if (branch_i) begin
         occ_d = '0;
      end
   end

   always_comb begin
      outst_d = outst_q + CNT_W'(fire_req) - CNT_W'(resp);
      disc_d  = disc_q - CNT_W'(drop);
      faddr_d = fire_req ? faddr_q + 32'd4 : faddr_q;
      pc_d    = fire_out ? pc_q + (comp ? 32'd2 : 32'd4) : pc_q;
      if (branch_i) begin
         disc_d  = outst_d;
         faddr_d = {branch_addr_i[31:2], 2'b00};
         pc_d    = {branch_addr_i[31:1], 1'b0};
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < DEPTH; i++) begin
            word_q[i] <= 32'h0;
         end
         err_q   <= '0;
         occ_q   <= '0;
         outst_q <= '0;
         disc_q  <= '0;
         faddr_q <= PC_INIT;
         pc_q    <= PC_INIT;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            word_q[i] <= word_d[i];
         end
         err_q   <= err_d;
         occ_q   <= occ_d;
         outst_q <= outst_d;
         disc_q  <= disc_d;
         faddr_q <= faddr_d;
         pc_q    <= pc_d;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_prefetch_buffer.sv
// ============================================================================
//  Module      : tb_prefetch_buffer
//  Description : Directed self-checking bench for prefetch_buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_prefetch_buffer;

   logic        clk = 1'b0;
   logic        rstn;
   logic        req, gnt, rvalid, rerr, branch, ready;
   logic [31:0] addr, rdata, baddr;
   logic        valid, comp, oerr, busy;
   logic [31:0] instr, pc;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   prefetch_buffer #(
      .PC_RESET        (32'h0000_0100),
      .DEPTH           (3),
      .NUM_OUTSTANDING (2)
   ) dut (
      .clk              (clk),
      .rstn             (rstn),
      .instr_req_o      (req),
      .instr_gnt_i      (gnt),
      .instr_addr_o     (addr),
      .instr_rvalid_i   (rvalid),
      .instr_rdata_i    (rdata),
      .instr_err_i      (rerr),
      .branch_i         (branch),
      .branch_addr_i    (baddr),
      .out_valid_o      (valid),
      .out_ready_i      (ready),
      .out_instr_o      (instr),
      .out_pc_o         (pc),
      .out_compressed_o (comp),
      .out_err_o        (oerr),
      .busy_o           (busy)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      rstn = 1'b0; gnt = 1'b0; rvalid = 1'b0; rerr = 1'b0; rdata = 32'h0;
      branch = 1'b0; baddr = 32'h0; ready = 1'b0;
      tick(); tick();
      chk("rst_req",   req,   0);
      chk("rst_valid", valid, 0);
      chk("rst_busy",  busy,  0);
      chk("rst_err",   oerr,  0);
      chk("rst_addr",  addr,  32'h100);
      chk("rst_pc",    pc,    32'h100);

      // Sequential fetch: compressed pair then a 32-bit word
      rstn = 1'b1; gnt = 1'b1;
      #1;
      chk("a_req0",  req,  1);
      chk("a_addr0", addr, 32'h100);
      tick();
      rvalid = 1'b1; rdata = 32'h4505_4501;
      chk("a_addr1", addr,  32'h104);
      chk("a_busy1", busy,  1);
      chk("a_lat",   valid, 0);
      tick();
      gnt = 1'b0; rdata = 32'h0000_0013; ready = 1'b1;
      chk("a_v0",  valid, 1);
      chk("a_pc0", pc,    32'h100);
      chk("a_i0",  instr, 32'h0000_4501);
      chk("a_c0",  comp,  1);
      tick();
      rvalid = 1'b0;
      chk("a_pc1",   pc,    32'h102);
      chk("a_i1",    instr, 32'h0000_4505);
      chk("a_v1",    valid, 1);
      chk("a_hold",  addr,  32'h108);
      chk("a_busy2", busy,  0);
      tick();
      chk("a_pc2", pc,    32'h104);
      chk("a_i2",  instr, 32'h0000_0013);
      chk("a_c2",  comp,  0);
      tick();
      chk("a_empty", valid, 0);
      chk("a_pc3",   pc,    32'h108);

      // 32-bit instruction straddling two words
      ready = 1'b0; branch = 1'b1; baddr = 32'h100;
      tick();
      branch = 1'b0; gnt = 1'b1;
      chk("c_pc",   pc,   32'h100);
      chk("c_addr", addr, 32'h100);
      tick();
      rvalid = 1'b1; rdata = 32'h0093_4501;
      tick();
      rvalid = 1'b0; gnt = 1'b0; ready = 1'b1;
      chk("c_v0", valid, 1);
      chk("c_i0", instr, 32'h0000_4501);
      tick();
      chk("c_wait", valid, 0);
      chk("c_pcw",  pc,    32'h102);
      rvalid = 1'b1; rdata = 32'h0000_00A0;
      tick();
      rvalid = 1'b0; ready = 1'b0;
      chk("c_v1",  valid, 1);
      chk("c_pc1", pc,    32'h102);
      chk("c_i1",  instr, 32'h00A0_0093);
      chk("c_c1",  comp,  0);

      // Two requests in flight, then branch drops both responses
      ready = 1'b1; gnt = 1'b1;
      tick();
      ready = 1'b0;
      tick();
      gnt = 1'b0;
      chk("d_req",  req,  0);
      chk("d_busy", busy, 1);
      chk("d_addr", addr, 32'h110);
      branch = 1'b1; baddr = 32'h207;
      tick();
      branch = 1'b0;
      chk("d_flush", valid, 0);
      chk("d_pc",    pc,    32'h206);
      chk("d_addr2", addr,  32'h204);
      chk("d_req2",  req,   0);
      rvalid = 1'b1; rdata = 32'hDEAD_BEEF;
      tick();
      chk("d_req3",  req,   1);
      chk("d_addr3", addr,  32'h204);
      chk("d_drop1", valid, 0);
      tick();
      rvalid = 1'b0;
      chk("d_drop2", valid, 0);
      chk("d_busy2", busy,  0);
      gnt = 1'b1;
      chk("d_addr4", addr, 32'h204);
      tick();
      gnt = 1'b0; rvalid = 1'b1; rdata = 32'h4581_0000;
      tick();
      rvalid = 1'b0;
      chk("d_v",  valid, 1);
      chk("d_pc5", pc,   32'h206);
      chk("d_i",  instr, 32'h0000_4581);

      // Back-pressure: requests stop while the buffer is fully committed
      gnt = 1'b1;
      tick();
      rvalid = 1'b1; rdata = 32'h0000_0013;
      tick();
      chk("e_req_full1", req, 0);
      tick();
      rvalid = 1'b0; gnt = 1'b0;
      chk("e_req_full2", req,  0);
      chk("e_busy",      busy, 0);
      chk("e_addr",      addr, 32'h210);
      ready = 1'b1;
      tick();
      ready = 1'b0;
      chk("e_req_resume", req,   1);
      chk("e_addr2",      addr,  32'h210);
      chk("e_pc",         pc,    32'h208);
      chk("e_i",          instr, 32'h0000_0013);

      // Bus error response
      branch = 1'b1; baddr = 32'h300;
      tick();
      branch = 1'b0; gnt = 1'b1;
      tick();
      gnt = 1'b0; rvalid = 1'b1; rerr = 1'b1; rdata = 32'h1234_5678;
      tick();
      rvalid = 1'b0; rerr = 1'b0;
      chk("f_v",   valid, 1);
      chk("f_err", oerr,  1);
      chk("f_i",   instr, 32'h0);
      chk("f_pc",  pc,    32'h300);

      // Branch wins over a same-cycle handshake
      ready = 1'b1; branch = 1'b1; baddr = 32'h400;
      tick();
      branch = 1'b0; ready = 1'b0;
      chk("g_pc",  pc,    32'h400);
      chk("g_v",   valid, 0);
      chk("g_err", oerr,  0);

      // Reset in the middle of a transaction
      gnt = 1'b1;
      tick();
      gnt = 1'b0;
      chk("h_busy", busy, 1);
      rstn = 1'b0;
      #1;
      chk("h_rbusy", busy, 0);
      chk("h_rreq",  req,  0);
      chk("h_raddr", addr, 32'h100);
      chk("h_rpc",   pc,   32'h100);
      tick();
      rstn = 1'b1; rvalid = 1'b1; rdata = 32'h0000_0013;
      tick();
      rvalid = 1'b0;
      chk("h_ignored", valid, 0);
      chk("h_busy2",   busy,  0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/prefetch_buffer.md
PREFETCH_BUFFER -- requirements
Module: prefetch_buffer

Interface
REQ-001 SHALL have parameter PC_RESET, default 32'h0000_0000, fetch and output PC after reset.
REQ-002 SHALL have parameter DEPTH, default 3, FIFO word entries (legal >=2).
REQ-003 SHALL have parameter NUM_OUTSTANDING, default 2, max granted-but-unanswered bus requests (legal 1..DEPTH).
REQ-004 SHALL use a single clock and an asynchronous, active-low reset.
REQ-005 clk  in  1  clock, all state on rising edge.
REQ-006 rstn  in  1  asynchronous active-low reset.
REQ-007 instr_req_o  out  1  bus request.
REQ-008 instr_gnt_i  in  1  request accepted this cycle.
REQ-009 instr_addr_o  out  32  word-aligned fetch address ([1:0]=0).
REQ-010 instr_rvalid_i  in  1  response valid.
REQ-011 instr_rdata_i  in  32  response word.
REQ-012 instr_err_i  in  1  response error, qualified by rvalid.
REQ-013 branch_i  in  1  redirect fetch; flush buffer.
REQ-014 branch_addr_i  in  32  redirect target; bit0 ignored.
REQ-015 out_valid_o  out  1  instruction available.
REQ-016 out_ready_i  in  1  consumer accepts.
REQ-017 out_instr_o  out  32  instruction; compressed zero-extended to 32.
REQ-018 out_pc_o  out  32  address of out_instr_o, bit0=0.
REQ-019 out_compressed_o  out  1  out_instr_o[1:0]!=2'b11.
REQ-020 out_err_o  out  1  instruction sourced from an errored word.
REQ-021 busy_o  out  1  outstanding count non-zero.

Function
REQ-022 Request rule: instr_req_o=1 iff outstanding<NUM_OUTSTANDING and (occupied+outstanding-discard)<DEPTH, where discard is the pending-drop counter.
REQ-023 Once instr_req_o=1 without instr_gnt_i, instr_req_o and instr_addr_o SHALL stay stable next cycle unless branch_i=1.
REQ-024 On req&gnt: fetch address += 4 (wraps mod 2^32), outstanding += 1.
REQ-025 On rvalid: outstanding -= 1; if discard>0 the word is dropped and discard -= 1, else {rdata,err} pushed to lowest free entry.
REQ-026 Simultaneous gnt and rvalid SHALL leave outstanding unchanged; rvalid with outstanding==0 SHALL be ignored.
REQ-027 Output sources only from FIFO entries, never directly from instr_rdata_i (1-cycle min fetch-to-output latency).
REQ-028 Aligned (out_pc_o[1]=0): valid when entry0 occupied; instr = entry0 word, or {16'h0,entry0[15:0]} if compressed.
REQ-029 Unaligned (out_pc_o[1]=1): if entry0[17:16]!=2'b11 valid with entry0 only, instr={16'h0,entry0[31:16]}; else valid needs entry0 and entry1, instr={entry1[15:0],entry0[31:16]}.
REQ-030 out_err_o = err of any entry contributing to the instruction; when out_err_o=1, out_valid_o asserts once entry0 is occupied and out_instr_o=0.
REQ-031 On out_valid_o&out_ready_i: out_pc_o += 2 if compressed else 4; entry0 popped when instruction ends at/after word boundary (aligned 32-bit, or unaligned any); remaining entries shift down one.
REQ-032 Push and pop in same cycle SHALL both take effect; pushed word lands in new lowest free entry.
REQ-033 Full: no push possible since REQ-022 reserves space per outstanding request.
REQ-034 branch_i=1: FIFO emptied next cycle, out_valid_o=0 next cycle, discard := outstanding after this cycle's gnt/rvalid, fetch address := {branch_addr_i[31:2],2'b00}, out_pc_o := {branch_addr_i[31:1],1'b0}.
REQ-035 branch_i SHALL override a same-cycle out handshake (no PC increment) and a same-cycle push.
REQ-036 busy_o = (outstanding!=0), combinational from registered count.

Reset
REQ-037 While rstn=0: instr_req_o=0, out_valid_o=0, out_err_o=0, busy_o=0, FIFO empty, outstanding=discard=0, instr_addr_o=out_pc_o={PC_RESET[31:2],2'b00}.
REQ-038 Reset mid-transaction SHALL drop all state; responses arriving after release with outstanding==0 are ignored.

Verification
REQ-039 Reset, PC_RESET=0x100, gnt always, rvalid 1 cycle later with 0x00A00093 -> addr 0x100,0x104; out_pc 0x100, instr 0x00A00093, compressed=0.
REQ-040 Words 0x4505_4501 then 0x0000_0013 -> outputs pc 0x100 instr 0x4501, pc 0x102 instr 0x4505, pc 0x104 instr 0x13.
REQ-041 Word0 0x0093_4501, word1 0x0000_00A0 -> pc 0x100 instr 0x4501; pc 0x102 instr 0x00A0_0093 valid only after word1 arrives.
REQ-042 Two outstanding, branch_i to 0x206 -> both old responses dropped, next request addr 0x204, first out_pc 0x206.
REQ-043 out_ready_i=0 until FIFO has DEPTH entries -> instr_req_o=0 while occupied+outstanding=DEPTH; resumes after one pop.
REQ-044 rvalid with err=1 at 0x300 -> out_valid=1, out_err=1, out_instr=0, out_pc=0x300.
